// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding LSU bridging the EX/MEM stage to a word-wide req/ack memory port
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    input  logic        is_load_i,
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic [31:0] load_data_o,
    output logic        load_valid_o,
    output logic        error_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_wstrb_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t state, state_n;
    logic [2:0] f3_q;
    logic [1:0] off_q;
    logic [1:0] sz;
    logic ld_ok, st_ok, mis, legal, idle, accept, bad;
    logic [3:0] strb;
    logic [7:0] b;
    logic [15:0] h;
    logic [31:0] ext;
    assign sz = funct3_i[1:0];
    assign idle = state == IDLE;
    assign ld_ok = (sz != 2'b11) & ~(funct3_i[2] & funct3_i[1]);
    assign st_ok = ~funct3_i[2] & (sz != 2'b11);
    assign mis = ((sz == 2'b01) & addr_i[0]) | ((sz == 2'b10) & |addr_i[1:0]);
    assign legal = is_load_i ? ld_ok : st_ok;
    assign accept = idle & req_valid_i & (is_load_i ^ is_store_i) & legal & ~mis;
    assign bad = idle & req_valid_i & (is_load_i | is_store_i) & ~accept;
    assign stall_o = accept | (state == WAIT);
    assign mem_req_o = state == WAIT;
    assign load_valid_o = (state == DONE) & ~mem_we_o;
    assign strb = (sz == 2'b00) ? 4'b0001 : (sz == 2'b01) ? 4'b0011 : 4'b1111;
    assign b = mem_rdata_i[{off_q, 3'b000} +: 8];
    assign h = mem_rdata_i[{off_q[1], 4'b0000} +: 16];
    assign ext = (f3_q[1:0] == 2'b00) ? {{24{~f3_q[2] & b[7]}}, b} :
                 (f3_q[1:0] == 2'b01) ? {{16{~f3_q[2] & h[15]}}, h} : mem_rdata_i;
    always_comb begin
        state_n = state;
        state_n = idle ? (accept ? WAIT : IDLE) :
                  (state == WAIT) ? (mem_ack_i ? DONE : WAIT) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            error_o     <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wstrb_o <= '0;
            mem_wdata_o <= '0;
            f3_q        <= '0;
            off_q       <= '0;
            load_data_o <= '0;
        end else begin
            state   <= state_n;
            error_o <= bad;
            if (accept) begin
                mem_addr_o  <= {addr_i[31:2], 2'b00};
                mem_we_o    <= is_store_i;
                mem_wstrb_o <= is_store_i ? strb << addr_i[1:0] : 4'b0000;
                mem_wdata_o <= (sz == 2'b00) ? {4{wdata_i[7:0]}} :
                               (sz == 2'b01) ? {2{wdata_i[15:0]}} : wdata_i;
                f3_q        <= funct3_i;
                off_q       <= addr_i[1:0];
            end
            if ((state == WAIT) && mem_ack_i && !mem_we_o)
                load_data_o <= ext;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven directed checks plus reset-in-WAIT and back-to-back sequences
module tb_load_store_unit;
    logic clk = 1'b0, rst = 1'b1;
    logic req_valid = 1'b0, is_load = 1'b0, is_store = 1'b0, mem_ack = 1'b0;
    logic [2:0] funct3 = '0;
    logic [31:0] addr = '0, wdata = '0, mem_rdata = '0;
    logic stall_o, load_valid_o, error_o, mem_req_o, mem_we_o;
    logic [31:0] load_data_o, mem_addr_o, mem_wdata_o;
    logic [3:0] mem_wstrb_o;
    int total = 0, passed = 0, rises = 0;
    logic req_prev = 1'b0;
    logic [31:0] last_ld = '0;

    load_store_unit dut (
        .clk(clk), .rst(rst), .req_valid_i(req_valid), .is_load_i(is_load),
        .is_store_i(is_store), .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata),
        .stall_o(stall_o), .load_data_o(load_data_o), .load_valid_o(load_valid_o),
        .error_o(error_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wstrb_o(mem_wstrb_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_req_o && !req_prev) rises++;
        req_prev = mem_req_o;
    end

    typedef struct {
        logic ld; logic st; logic [2:0] f3; logic [31:0] addr; logic [31:0] wdata;
        logic [31:0] rdata; int lat; logic err; logic [31:0] eaddr; logic [3:0] estrb;
        logic [31:0] ewdata; logic [31:0] eldata;
    } vec_t;
    vec_t vec[14];

    task chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else passed++;
    endtask

    task apply(input vec_t v);
        int n;
        n = 0;
        @(negedge clk);
        req_valid = 1; is_load = v.ld; is_store = v.st; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
        #1 chk("stall_accept", stall_o, !v.err);
        if (stall_o) n++;
        @(negedge clk);
        req_valid = 0;
        if (v.err) begin
            chk("err_pulse", error_o, 1);
            chk("err_noreq", mem_req_o, 0);
            chk("err_stall", stall_o, 0);
            @(negedge clk);
            chk("err_clear", error_o, 0);
            chk("err_noreq2", mem_req_o, 0);
        end else begin
            chk("mem_addr", mem_addr_o, v.eaddr);
            chk("mem_we", mem_we_o, v.st);
            chk("mem_wstrb", mem_wstrb_o, v.estrb);
            if (v.st) chk("mem_wdata", mem_wdata_o, v.ewdata);
            for (int w = 1; w <= v.lat; w++) begin
                chk("wait_req", mem_req_o, 1);
                chk("wait_addr", mem_addr_o, v.eaddr);
                if (stall_o) n++;
                if (w == v.lat) begin mem_ack = 1; mem_rdata = v.rdata; end
                @(negedge clk);
            end
            mem_ack = 0;
            chk("done_valid", load_valid_o, v.ld);
            chk("done_req", mem_req_o, 0);
            chk("done_stall", stall_o, 0);
            if (v.ld) last_ld = v.eldata;
            chk("load_data", load_data_o, last_ld);
            chk("stall_cycles", n, v.lat + 1);
            @(negedge clk);
            chk("valid_pulse", load_valid_o, 0);
        end
    endtask

    initial begin
        vec[0]  = '{1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 3, 0, 32'h100, 4'b0000, 32'h0, 32'hDEADBEEF};
        vec[1]  = '{1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 1, 0, 32'h100, 4'b0000, 32'h0, 32'hFFFFFF80};
        vec[2]  = '{1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 2, 0, 32'h100, 4'b0000, 32'h0, 32'h00000080};
        vec[3]  = '{1, 0, 3'b001, 32'h102, 32'h0, 32'h80010000, 1, 0, 32'h100, 4'b0000, 32'h0, 32'hFFFF8001};
        vec[4]  = '{1, 0, 3'b101, 32'h102, 32'h0, 32'h80010000, 1, 0, 32'h100, 4'b0000, 32'h0, 32'h00008001};
        vec[5]  = '{0, 1, 3'b000, 32'h201, 32'h000000AB, 32'h0, 2, 0, 32'h200, 4'b0010, 32'hABABABAB, 32'h0};
        vec[6]  = '{0, 1, 3'b001, 32'h202, 32'h00001234, 32'h0, 1, 0, 32'h200, 4'b1100, 32'h12341234, 32'h0};
        vec[7]  = '{0, 1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0, 1, 0, 32'h300, 4'b1111, 32'hCAFEF00D, 32'h0};
        vec[8]  = '{1, 0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 1, 32'h0, 4'b0000, 32'h0, 32'h0};
        vec[9]  = '{0, 1, 3'b001, 32'h101, 32'h0, 32'h0, 0, 1, 32'h0, 4'b0000, 32'h0, 32'h0};
        vec[10] = '{1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 1, 32'h0, 4'b0000, 32'h0, 32'h0};
        vec[11] = '{1, 1, 3'b010, 32'h100, 32'h0, 32'h0, 0, 1, 32'h0, 4'b0000, 32'h0, 32'h0};
        vec[12] = '{0, 1, 3'b100, 32'h100, 32'h0, 32'h0, 0, 1, 32'h0, 4'b0000, 32'h0, 32'h0};
        vec[13] = '{1, 0, 3'b000, 32'h101, 32'h0, 32'h00007F00, 1, 0, 32'h100, 4'b0000, 32'h0, 32'h0000007F};
        repeat (2) @(negedge clk);
        chk("rst_req", mem_req_o, 0);
        chk("rst_we", mem_we_o, 0);
        chk("rst_strb", mem_wstrb_o, 0);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_wdata", mem_wdata_o, 0);
        chk("rst_ldata", load_data_o, 0);
        chk("rst_lvalid", load_valid_o, 0);
        chk("rst_err", error_o, 0);
        chk("rst_stall", stall_o, 0);
        rst = 0;
        for (int i = 0; i < 14; i++) apply(vec[i]);
        // request with neither load nor store is ignored
        @(negedge clk);
        req_valid = 1; is_load = 0; is_store = 0; funct3 = 3'b010; addr = 32'h100;
        #1 chk("nop_stall", stall_o, 0);
        @(negedge clk);
        req_valid = 0;
        chk("nop_err", error_o, 0);
        chk("nop_req", mem_req_o, 0);
        // reset while waiting, then a late ack
        @(negedge clk);
        req_valid = 1; is_load = 1; funct3 = 3'b010; addr = 32'h400;
        @(negedge clk);
        req_valid = 0;
        chk("rw_req", mem_req_o, 1);
        rst = 1;
        @(negedge clk);
        rst = 0; mem_ack = 1; mem_rdata = 32'h12345678;
        chk("rw_req_off", mem_req_o, 0);
        chk("rw_stall", stall_o, 0);
        chk("rw_ldata", load_data_o, 0);
        @(negedge clk);
        mem_ack = 0;
        chk("rw_no_valid", load_valid_o, 0);
        chk("rw_req_off2", mem_req_o, 0);
        req_valid = 1; is_load = 1; funct3 = 3'b010; addr = 32'h400;
        #1 chk("rw_idle_accept", stall_o, 1);
        @(negedge clk);
        req_valid = 0; mem_ack = 1; mem_rdata = 32'h0BADF00D;
        @(negedge clk);
        mem_ack = 0;
        chk("rw_recover", load_data_o, 32'h0BADF00D);
        @(negedge clk);
        // back-to-back SW then LW, same-cycle ack, request held throughout
        rises = 0;
        req_valid = 1; is_load = 0; is_store = 1; funct3 = 3'b010; addr = 32'h500; wdata = 32'h11223344;
        @(negedge clk);
        is_load = 1; is_store = 0; addr = 32'h504; mem_ack = 1; mem_rdata = 32'h55667788;
        chk("b2b_sw_we", mem_we_o, 1);
        chk("b2b_sw_addr", mem_addr_o, 32'h500);
        @(negedge clk);
        mem_ack = 0;
        chk("b2b_done_req", mem_req_o, 0);
        chk("b2b_done_stall", stall_o, 0);
        chk("b2b_sw_novalid", load_valid_o, 0);
        @(negedge clk);
        chk("b2b_idle_stall", stall_o, 1);
        chk("b2b_idle_req", mem_req_o, 0);
        @(negedge clk);
        req_valid = 0;
        chk("b2b_lw_req", mem_req_o, 1);
        chk("b2b_lw_we", mem_we_o, 0);
        chk("b2b_lw_addr", mem_addr_o, 32'h504);
        mem_ack = 1;
        @(negedge clk);
        mem_ack = 0;
        chk("b2b_lw_valid", load_valid_o, 1);
        chk("b2b_lw_data", load_data_o, 32'h55667788);
        @(negedge clk);
        chk("b2b_bursts", rises, 2);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
